mat_mult_operand_streamer: RTL and testbench
============================================

Name: mat_mult_operand_streamer

Overview:
- Host-side companion to the 8x8 systolic array matrix multiplier.
- Host loads the A and B operand matrices into local row buffers. On launch the block pulses start and streams A and B rows over the array's valid/ready operand ports, one row per beat.
- It then accepts the 8 C result rows over the array's c_valid/c_ready port into a result buffer that the host reads back.
- It is the transmitter for the array's A/B receivers and the receiver for its C transmitter.

Parameters:
- N, 8, matrix dimension (rows per matrix, elements per row).
- DATA_WIDTH, 8, signed operand element width.
- ACC_WIDTH, 32, signed result element width.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- wr_en  in  1  host operand write strobe.
- wr_sel  in  1  0 = A buffer, 1 = B buffer.
- wr_row  in  $clog2(N)  row index for host write.
- wr_data  in  N x DATA_WIDTH signed  row written.
- launch  in  1  start a multiply.
- busy  out  1  high from launch acceptance until done.
- done  out  1  one-cycle pulse when all C rows are captured.
- rd_row  in  $clog2(N)  C buffer read index.
- rd_data  out  N x ACC_WIDTH signed  C row, registered, 1-cycle latency.
- mm_start  out  1  one-cycle start pulse to the array.
- mm_ready  in  1  array idle/ready.
- a_valid  out  1  A row valid.
- a_ready  in  1  array accepts A row.
- a_out  out  N x DATA_WIDTH signed  A row.
- b_valid  out  1  B row valid.
- b_ready  in  1  array accepts B row.
- b_out  out  N x DATA_WIDTH signed  B row.
- c_valid  in  1  array C row valid.
- c_ready  out  1  streamer accepts C row.
- c_in  in  N x ACC_WIDTH signed  C row.

Behaviour:
- Reset (rst low, asynchronous):
  - state = IDLE; a_ptr, b_ptr, c_ptr = 0.
  - busy, done, mm_start, a_valid, b_valid, c_ready = 0; rd_data = 0.
  - A/B/C buffer contents are not reset.
  - Reset mid-operation abandons the transfer with no done pulse.
- Host writes:
  - When wr_en and not busy, the row is written to buffer[wr_sel][wr_row] on the next edge.
  - Writes while busy are ignored.
- FSM states and transitions:
  - IDLE: launch & mm_ready -> START. Launch with mm_ready low is ignored (not queued).
  - START: mm_start = 1 for exactly one cycle, busy = 1 -> FEED.
  - FEED:
    - a_valid = 1 while a_ptr < N; b_valid = 1 while b_ptr < N.
    - A and B pointers advance independently on their own valid & ready.
    - Both A and B start valid in the same cycle.
    - c_ready = 1.
    - -> DRAIN when both A and B have completed N beats (the final beat counts in its own cycle).
  - DRAIN: c_ready = 1 while c_ptr < N. -> DONE when the Nth C beat is accepted.
  - DONE: done = 1 for one cycle, busy drops the same cycle -> IDLE.
- Handshake:
  - A row transfers when valid & ready on a rising edge.
  - valid never drops, and the data never changes, until acceptance.
  - a_out = A[a_ptr] and b_out = B[b_ptr] when valid, else all zeros.
- C capture:
  - On c_valid & c_ready, c_in is written to C[c_ptr] and c_ptr increments.
  - c_ready = 0 once c_ptr = N, so extra C beats stall at the array and are not dropped by this block.
  - C beats arriving during FEED are accepted and counted.
- Read port:
  - rd_data <= C[rd_row] every cycle, independent of state.
  - Reads while busy may return mixed old/new rows.
- Pointer wrap: pointers are $clog2(N)+1 bits wide and never wrap mid-transfer; they are cleared in START.
- Simultaneous events: wr_en coincident with launch acceptance in IDLE takes effect, since the write lands before FEED reads.
- No arithmetic: data passes through unmodified, and signedness is preserved.

Optional Feature:
- Macro: MAT_MULT_STREAMER_PERF_EN.
- Defined:
  - Adds output cycle_count (32 bits).
  - Counter clears in START and increments every cycle while busy, saturating at all-ones.
  - Holds its value after done until the next START; reset value 0.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Package mat_mult_pkg:
  - N, DATA_WIDTH, ACC_WIDTH defaults.
  - Typedefs for the operand row (N x signed DATA_WIDTH) and result row (N x signed ACC_WIDTH).
  - Enum for the streamer FSM state {IDLE, START, FEED, DRAIN, DONE}.
- Sub-module: row_stream_tx, instantiated twice (A and B).
  - Contents: one row buffer, pointer, valid/ready source logic, and "finished" flag.
  - Inputs: load, clear, ready.

Test Plan:
- Identity test: write A = identity and B rows with b[i][j] = i*8+j, launch with a/b_ready tied 1 -> mm_start pulses once; 8 A and 8 B beats, A in rows 0..7 order; 8 C rows taken from model array; done pulses once; rd_row = 3 returns the model's row 3 one cycle later.
- Backpressure: a_ready toggles 1,0,0,1 and b_ready random -> a_out stable during stalls; exactly 8 beats each; FEED->DRAIN only after both finish.
- Extremes: A all -128, B all 127; inject C = -7340032 per element -> captured bit-exact, sign preserved on rd_data.
- Protection and extra beats: launch with mm_ready = 0 -> no mm_start; wr_en while busy -> buffer unchanged; 9th c_valid -> c_ready = 0 and not captured.
- Mid-op reset: assert rst low during DRAIN after 4 C beats -> all outputs 0 immediately; no done; a new launch completes normally.
- Perf counter (MAT_MULT_STREAMER_PERF_EN defined): ready tied 1 -> cycle_count equals the measured busy cycles; holds after done.

Source files
------------

// File: rtl/mat_mult_pkg.sv
// mat_mult_pkg
//   Shared sizing, row types and FSM state encoding for the host-side operand
//   streamer of the 8x8 systolic matrix multiplier.
//   N          : matrix dimension (rows per matrix, elements per row)
//   DATA_WIDTH : signed operand element width
//   ACC_WIDTH  : signed result element width
package mat_mult_pkg;

  localparam int N          = 8;
  localparam int DATA_WIDTH = 8;
  localparam int ACC_WIDTH  = 32;

  // Row index width and transfer pointer width (one extra bit so a pointer
  // can hold N itself and mark "all rows sent" without wrapping).
  localparam int IDX_W = $clog2(N);
  localparam int PTR_W = $clog2(N) + 1;

  localparam logic [PTR_W-1:0] PTR_N    = PTR_W'(N);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(N - 1);

  typedef logic signed [DATA_WIDTH-1:0] op_elem_t;
  typedef logic signed [ACC_WIDTH-1:0]  res_elem_t;
  typedef op_elem_t  [N-1:0] op_row_t;
  typedef res_elem_t [N-1:0] res_row_t;

  typedef enum logic [2:0] {
    IDLE,
    START,
    FEED,
    DRAIN,
    DONE
  } state_t;

endpackage

// File: rtl/mat_mult_operand_streamer_row_stream_tx.sv
// row_stream_tx
//   One operand row buffer plus the valid/ready transmitter that streams its
//   N rows in order, one row per accepted beat.
//   Ports:
//     clk          rising-edge clock
//     rst          asynchronous active-low reset (pointer only)
//     i_load       host write strobe into the row buffer
//     i_load_row   row index of host write
//     i_load_data  row written by host
//     i_clear      rewind pointer to row 0 (start of a new transfer)
//     i_en         transfer window open (valid may be raised)
//     i_ready      receiver accepts the current row
//     o_valid      current row is valid
//     o_data       current row, zero when not valid
//     o_finished   all N rows sent, including a final beat accepted this cycle
module row_stream_tx
  import mat_mult_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [IDX_W-1:0] i_load_row,
  input  op_row_t          i_load_data,
  input  logic             i_clear,
  input  logic             i_en,
  input  logic             i_ready,
  output logic             o_valid,
  output op_row_t          o_data,
  output logic             o_finished
);

  op_row_t          r_buf [N];
  logic [PTR_W-1:0] r_ptr;
  logic             w_fire;

  // Buffer contents survive reset; only the host ever writes them.
  always_ff @(posedge clk) begin
    if (i_load) r_buf[i_load_row] <= i_load_data;
  end

  assign o_valid = i_en && (r_ptr < PTR_N);
  assign w_fire  = o_valid && i_ready;
  assign o_data  = o_valid ? r_buf[r_ptr[IDX_W-1:0]] : '0;

  // Counting the last beat in its own cycle lets the FSM leave FEED on the
  // same edge that retires the final row.
  assign o_finished = (r_ptr == PTR_N) || (w_fire && (r_ptr == PTR_LAST));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         r_ptr <= '0;
    else if (i_clear) r_ptr <= '0;
    else if (w_fire)  r_ptr <= r_ptr + PTR_W'(1);
  end

endmodule

// File: rtl/mat_mult_operand_streamer.sv
// mat_mult_operand_streamer
//   Host-side companion to the 8x8 systolic array. The host loads A and B
//   into local row buffers; a launch pulses mm_start, streams A and B rows
//   over independent valid/ready ports, then collects N C rows into a result
//   buffer the host reads back through a registered read port.
//   Ports:
//     clk, rst                  clock, asynchronous active-low reset
//     wr_en/wr_sel/wr_row/wr_data  host operand write (sel 0 = A, 1 = B)
//     launch, busy, done        launch request, busy flag, done pulse
//     rd_row, rd_data           C buffer read (1-cycle latency)
//     mm_start, mm_ready        array start pulse / array idle
//     a_valid/a_ready/a_out     A row stream to the array
//     b_valid/b_ready/b_out     B row stream to the array
//     c_valid/c_ready/c_in      C row stream from the array
//     cycle_count               busy-cycle counter, present only when
//                               MAT_MULT_STREAMER_PERF_EN is defined
module mat_mult_operand_streamer
  import mat_mult_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic             wr_sel,
  input  logic [IDX_W-1:0] wr_row,
  input  op_row_t          wr_data,
  input  logic             launch,
  output logic             busy,
  output logic             done,
  input  logic [IDX_W-1:0] rd_row,
  output res_row_t         rd_data,
  output logic             mm_start,
  input  logic             mm_ready,
  output logic             a_valid,
  input  logic             a_ready,
  output op_row_t          a_out,
  output logic             b_valid,
  input  logic             b_ready,
  output op_row_t          b_out,
  input  logic             c_valid,
  output logic             c_ready,
  input  res_row_t         c_in
`ifdef MAT_MULT_STREAMER_PERF_EN
  ,
  output logic [31:0]      cycle_count
`endif
);

  state_t           r_state;
  state_t           w_next;
  logic             w_clear;
  logic             w_feed;
  logic             w_load_a;
  logic             w_load_b;
  logic             w_a_fin;
  logic             w_b_fin;
  logic             w_c_room;
  logic             w_c_fire;
  logic [PTR_W-1:0] r_c_ptr;
  res_row_t         r_c_buf [N];
  res_row_t         r_rd_data;

  // Host writes are blocked only while busy; a write in the launch cycle
  // still lands because IDLE is not busy and FEED starts two edges later.
  assign w_load_a = wr_en && !busy && !wr_sel;
  assign w_load_b = wr_en && !busy &&  wr_sel;

  row_stream_tx u_a_tx (
    .clk         (clk),
    .rst         (rst),
    .i_load      (w_load_a),
    .i_load_row  (wr_row),
    .i_load_data (wr_data),
    .i_clear     (w_clear),
    .i_en        (w_feed),
    .i_ready     (a_ready),
    .o_valid     (a_valid),
    .o_data      (a_out),
    .o_finished  (w_a_fin)
  );

  row_stream_tx u_b_tx (
    .clk         (clk),
    .rst         (rst),
    .i_load      (w_load_b),
    .i_load_row  (wr_row),
    .i_load_data (wr_data),
    .i_clear     (w_clear),
    .i_en        (w_feed),
    .i_ready     (b_ready),
    .o_valid     (b_valid),
    .o_data      (b_out),
    .o_finished  (w_b_fin)
  );

  assign w_c_room = (r_c_ptr < PTR_N);
  assign w_c_fire = c_valid && c_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    busy     = 1'b0;
    done     = 1'b0;
    mm_start = 1'b0;
    c_ready  = 1'b0;
    w_clear  = 1'b0;
    w_feed   = 1'b0;
    case (r_state)
      IDLE: begin
        // A launch while the array is not ready is dropped, not queued.
        if (launch && mm_ready) w_next = START;
      end
      START: begin
        mm_start = 1'b1;
        busy     = 1'b1;
        w_clear  = 1'b1;
        w_next   = FEED;
      end
      FEED: begin
        busy    = 1'b1;
        w_feed  = 1'b1;
        c_ready = w_c_room;
        if (w_a_fin && w_b_fin) w_next = DRAIN;
      end
      DRAIN: begin
        busy    = 1'b1;
        c_ready = w_c_room;
        // Early C beats taken during FEED may already have filled the buffer.
        if (!w_c_room || (c_valid && (r_c_ptr == PTR_LAST))) w_next = DONE;
      end
      DONE: begin
        done   = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          r_c_ptr <= '0;
    else if (w_clear)  r_c_ptr <= '0;
    else if (w_c_fire) r_c_ptr <= r_c_ptr + PTR_W'(1);
  end

  always_ff @(posedge clk) begin
    if (w_c_fire) r_c_buf[r_c_ptr[IDX_W-1:0]] <= c_in;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_rd_data <= '0;
    else      r_rd_data <= r_c_buf[rd_row];
  end

  assign rd_data = r_rd_data;

`ifdef MAT_MULT_STREAMER_PERF_EN
  logic [31:0] r_cycle_count;

  // START restarts the count and includes its own busy cycle, so the value
  // seen after done equals the number of cycles busy was high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                r_cycle_count <= '0;
    else if (r_state == START)               r_cycle_count <= 32'd1;
    else if (busy && (r_cycle_count != '1))  r_cycle_count <= r_cycle_count + 32'd1;
  end

  assign cycle_count = r_cycle_count;
`endif

endmodule

// File: tb/tb_mat_mult_operand_streamer.sv
module tb_mat_mult_operand_streamer;
  import mat_mult_pkg::*;

  logic             clk = 1'b0;
  logic             rst;
  logic             wr_en, wr_sel, launch, mm_ready, a_ready, b_ready, c_valid;
  logic [IDX_W-1:0] wr_row, rd_row;
  op_row_t          wr_data, a_out, b_out;
  res_row_t         rd_data, c_in;
  logic             busy, done, mm_start, a_valid, b_valid, c_ready;
`ifdef MAT_MULT_STREAMER_PERF_EN
  logic [31:0]      cycle_count;
`endif

  op_row_t  A_m [N];
  op_row_t  B_m [N];
  res_row_t C_send [N];
  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  mat_mult_operand_streamer dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_sel   (wr_sel),
    .wr_row   (wr_row),
    .wr_data  (wr_data),
    .launch   (launch),
    .busy     (busy),
    .done     (done),
    .rd_row   (rd_row),
    .rd_data  (rd_data),
    .mm_start (mm_start),
    .mm_ready (mm_ready),
    .a_valid  (a_valid),
    .a_ready  (a_ready),
    .a_out    (a_out),
    .b_valid  (b_valid),
    .b_ready  (b_ready),
    .b_out    (b_out),
    .c_valid  (c_valid),
    .c_ready  (c_ready),
    .c_in     (c_in)
`ifdef MAT_MULT_STREAMER_PERF_EN
    ,
    .cycle_count (cycle_count)
`endif
  );

  task automatic chk(input string tag, input logic [N*ACC_WIDTH-1:0] got,
                     input logic [N*ACC_WIDTH-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic op_row_t rand_row();
    op_row_t r;
    for (int j = 0; j < N; j++) r[j] = op_elem_t'($urandom);
    return r;
  endfunction

  // Reference product C = A x B over the matrices the bench believes are loaded.
  task automatic compute_c();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        int acc = 0;
        for (int k = 0; k < N; k++) acc += int'(A_m[i][k]) * int'(B_m[k][j]);
        C_send[i][j] = res_elem_t'(acc);
      end
  endtask

  task automatic host_write(input logic sel, input int row, input op_row_t data);
    wr_en = 1'b1; wr_sel = sel; wr_row = IDX_W'(row); wr_data = data;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic load_all();
    for (int r = 0; r < N; r++) host_write(1'b0, r, A_m[r]);
    for (int r = 0; r < N; r++) host_write(1'b1, r, B_m[r]);
  endtask

  task automatic rd_all(input string tag);
    for (int r = 0; r < N; r++) begin
      rd_row = IDX_W'(r);
      @(posedge clk); #1;
      chk(tag, rd_data, C_send[r]);
    end
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_mm_start"}, mm_start, 0);
    chk({tag, "_a_valid"}, a_valid, 0);
    chk({tag, "_b_valid"}, b_valid, 0);
    chk({tag, "_c_ready"}, c_ready, 0);
    chk({tag, "_a_out"}, a_out, 0);
    chk({tag, "_rd_data"}, rd_data, 0);
  endtask

  // Plays the systolic array: accepts A/B rows, returns C_send once both
  // operand streams are complete, and keeps offering a ninth C row.
  task automatic run_op(input bit bp, input bit wr_busy, input bit coinc,
                        input bit use_model, input int abort_c);
    int na = 0, nb = 0, nc = 0, nstart = 0, ndone = 0, nbusy = 0;
    bit a_st = 0, b_st = 0, fin = 0;
    op_row_t a_h = '0, b_h = '0;
    logic [3:0] a_pat = 4'b1001;
    mm_ready = 1'b1;
    launch   = 1'b1;
    if (coinc) begin
      A_m[0] = rand_row();
      wr_en = 1'b1; wr_sel = 1'b0; wr_row = '0; wr_data = A_m[0];
    end
    if (use_model) compute_c();
    @(posedge clk); #1;
    launch = 1'b0; wr_en = 1'b0;
    for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
      if (abort_c > 0 && nc == abort_c) begin
        c_valid = 1'b0;
        rst = 1'b0;
        #1;
        chk_outputs_zero("abort");
        chk("abort_no_done", ndone, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        return;
      end
      a_ready = bp ? a_pat[cyc % 4] : 1'b1;
      b_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      c_valid = (na == N) && (nb == N);
      c_in    = (nc < N) ? C_send[nc] : ~C_send[0];
      if (wr_busy && busy) begin
        wr_en = 1'b1; wr_sel = 1'(cyc % 2); wr_row = IDX_W'(cyc % N);
        wr_data = {$urandom, $urandom};
      end else begin
        wr_en = 1'b0;
      end
      #1;
      if (mm_start) nstart++;
      if (busy) nbusy++;
      if (a_st) begin chk("a_stall_valid", a_valid, 1); chk("a_stall_data", a_out, a_h); end
      if (b_st) begin chk("b_stall_valid", b_valid, 1); chk("b_stall_data", b_out, b_h); end
      if (a_valid) begin
        if (na < N) chk("a_row", a_out, A_m[na]); else chk("a_extra_valid", a_valid, 0);
        if (a_ready) na++;
      end
      if (b_valid) begin
        if (nb < N) chk("b_row", b_out, B_m[nb]); else chk("b_extra_valid", b_valid, 0);
        if (b_ready) nb++;
      end
      a_st = a_valid && !a_ready; a_h = a_out;
      b_st = b_valid && !b_ready; b_h = b_out;
      if (c_valid && nc == N) chk("c_extra_ready", c_ready, 0);
      if (c_valid && c_ready) nc++;
      if (done) begin ndone++; chk("done_busy_low", busy, 0); fin = 1; end
      @(posedge clk); #1;
    end
    c_valid = 1'b0; wr_en = 1'b0; a_ready = 1'b1; b_ready = 1'b1;
    chk("op_finished", fin, 1);
    chk("mm_start_pulses", nstart, 1);
    chk("a_beats", na, N);
    chk("b_beats", nb, N);
    chk("c_beats", nc, N);
    chk("done_one_cycle", done, 0);
    chk("idle_busy", busy, 0);
`ifdef MAT_MULT_STREAMER_PERF_EN
    chk("perf_count", cycle_count, nbusy);
    repeat (3) @(posedge clk);
    #1;
    chk("perf_hold", cycle_count, nbusy);
`endif
  endtask

  initial begin
    rst = 1'b0; wr_en = 0; wr_sel = 0; wr_row = '0; wr_data = '0; launch = 0;
    mm_ready = 1; a_ready = 1; b_ready = 1; c_valid = 0; c_in = '0; rd_row = '0;
    #1;
    chk_outputs_zero("reset");
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // Identity A, counting B: product equals B.
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        A_m[i][j] = (i == j) ? op_elem_t'(1) : op_elem_t'(0);
        B_m[i][j] = op_elem_t'(i * 8 + j);
      end
    load_all();
    run_op(0, 0, 0, 1, 0);
    rd_row = IDX_W'(3);
    @(posedge clk); #1;
    chk("ident_row3", rd_data, C_send[3]);
    rd_all("ident_c");

    // Random matrices under backpressure, with a write in the launch cycle
    // and writes attempted throughout the busy window.
    for (int r = 0; r < N; r++) begin A_m[r] = rand_row(); B_m[r] = rand_row(); end
    load_all();
    run_op(1, 1, 1, 1, 0);
    rd_all("bp_c");
    run_op(0, 0, 0, 1, 0);
    rd_all("reuse_c");

    // Extremes: sign and full-width values pass through unchanged.
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        A_m[i][j] = op_elem_t'(-128);
        B_m[i][j] = op_elem_t'(127);
        C_send[i][j] = res_elem_t'(-7340032);
      end
    load_all();
    run_op(1, 0, 0, 0, 0);
    rd_all("extreme_c");

    // Launch while the array is not ready is ignored and not remembered.
    mm_ready = 1'b0; launch = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      chk("noready_mm_start", mm_start, 0);
      chk("noready_busy", busy, 0);
    end
    launch = 1'b0; mm_ready = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      chk("noready_no_queue", mm_start, 0);
    end

    // Reset in DRAIN after four C rows, then a clean operation.
    for (int r = 0; r < N; r++) begin A_m[r] = rand_row(); B_m[r] = rand_row(); end
    load_all();
    run_op(0, 0, 0, 1, 4);
    chk_outputs_zero("post_abort");
    run_op(1, 0, 0, 1, 0);
    rd_all("after_abort_c");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
